// File: rtl/memory_subsystem.sv
// rtl/memory_subsystem.sv - MAR/MDR front end with a preloadable word array and write counter
module memory_subsystem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic                  Mem_enable512x32,
    input  logic                  run,
    input  logic                  pre_we,
    input  logic [ADDR_WIDTH-1:0] pre_addr,
    input  logic [DATA_WIDTH-1:0] pre_data,
    output logic [DATA_WIDTH-1:0] MDR_q,
    output logic [ADDR_WIDTH-1:0] MAR_q,
    output logic                  mem_fault,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] MAR_d;
    logic [DATA_WIDTH-1:0] MDR_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic                  mem_fault_q, mem_fault_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_en;
    logic                  cpu_wr;
    logic                  pre_wr;
    logic                  fault_evt;

    always_comb begin
        mem_rdata   = mem_q[MAR_q];
        rd_en       = Mem_Read & Mem_enable512x32;
        // A simultaneous read wins over the write; reset also blocks the commit.
        cpu_wr      = Mem_Write & Mem_enable512x32 & ~Mem_Read & ~reset;
        pre_wr      = pre_we & ~run;
        fault_evt   = (Mem_Read & Mem_Write & Mem_enable512x32) | (pre_we & run);

        MAR_d       = MARin ? BusMuxOut[ADDR_WIDTH-1:0] : MAR_q;
        MDR_d       = MDR_q;
        if (MDRin) begin
            MDR_d = rd_en ? mem_rdata : BusMuxOut;
        end
        wr_count_d  = cpu_wr ? wr_count_q + 16'd1 : wr_count_q;
        mem_fault_d = mem_fault_q | fault_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MAR_q       <= '0;
            MDR_q       <= '0;
            wr_count_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            MAR_q       <= MAR_d;
            MDR_q       <= MDR_d;
            wr_count_q  <= wr_count_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    // Array has no reset so preloaded programs survive a CPU reset; the CPU write is
    // issued last so it overrides a preload to the same word on the same edge.
    always_ff @(posedge clk) begin
        if (pre_wr) begin
            mem_q[pre_addr] <= pre_data;
        end
        if (cpu_wr) begin
            mem_q[MAR_q] <= MDR_q;
        end
    end

    assign wr_count  = wr_count_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_memory_subsystem.sv
// tb/tb_memory_subsystem.sv - randomized and directed checks of memory_subsystem against a behavioural model
module tb_memory_subsystem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Mem_Read, Mem_Write, Mem_enable512x32, run, pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] MDR_q;
    logic [8:0]  MAR_q;
    logic        mem_fault;
    logic [15:0] wr_count;

    memory_subsystem #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clk(clk), .reset(reset), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_enable512x32(Mem_enable512x32), .run(run), .pre_we(pre_we),
        .pre_addr(pre_addr), .pre_data(pre_data),
        .MDR_q(MDR_q), .MAR_q(MAR_q), .mem_fault(mem_fault), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [512];
    logic [31:0] pre_vals [512];
    logic [8:0]  m_mar = '0;
    logic [31:0] m_mdr = '0;
    int          m_cnt = 0;
    bit          m_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word semantics applied once per rising edge from the sampled inputs.
    always @(posedge clk) begin : model
        logic [31:0] rdv;
        bit          en;
        rdv = m_mem[m_mar];
        en  = Mem_enable512x32;
        if (pre_we && !run) m_mem[pre_addr] = pre_data;
        if (reset) begin
            m_mar = '0; m_mdr = '0; m_cnt = 0; m_fault = 1'b0;
        end else begin
            if (Mem_Write && en && !Mem_Read) begin
                m_mem[m_mar] = m_mdr;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if ((Mem_Read && Mem_Write && en) || (pre_we && run)) m_fault = 1'b1;
            if (MDRin) m_mdr = (Mem_Read && en) ? rdv : BusMuxOut;
            if (MARin) m_mar = BusMuxOut[8:0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_mar", {23'd0, MAR_q}, {23'd0, m_mar});
            check("cyc_mdr", MDR_q, m_mdr);
            check("cyc_cnt", {16'd0, wr_count}, m_cnt[31:0]);
            check("cyc_fault", {31'd0, mem_fault}, {31'd0, m_fault});
        end
    end

    task automatic idle();
        reset = 0; BusMuxOut = '0; MARin = 0; MDRin = 0; Mem_Read = 0; Mem_Write = 0;
        Mem_enable512x32 = 0; pre_we = 0; pre_addr = '0; pre_data = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_mar(input logic [31:0] v);
        idle(); MARin = 1; BusMuxOut = v; tick(); idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); MDRin = 1; BusMuxOut = v; tick(); idle();
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] d);
        load_mar({23'd0, a});
        Mem_Read = 1; Mem_enable512x32 = 1; MDRin = 1; tick(); idle();
        d = MDR_q;
    endtask

    logic [31:0] d;

    initial begin
        idle(); run = 0; reset = 1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_mar", {23'd0, MAR_q}, 32'd0);
        check("rst_mdr", MDR_q, 32'd0);
        check("rst_cnt", {16'd0, wr_count}, 32'd0);
        check("rst_fault", {31'd0, mem_fault}, 32'd0);

        for (int i = 0; i < 512; i++) begin
            pre_vals[i] = $urandom;
            if (i == 5) pre_vals[i] = 32'h0880_0003;
            if (i == 2) pre_vals[i] = 32'h0000_000A;
            if (i == 7) pre_vals[i] = 32'h0000_0077;
            if (i == 9) pre_vals[i] = 32'h0000_0099;
            idle(); pre_we = 1; pre_addr = i[8:0]; pre_data = pre_vals[i]; tick();
        end
        idle(); run = 1;

        // Fetch
        rd(9'd5, d);
        check("fetch_mdr", d, 32'h0880_0003);
        check("fetch_model", m_mdr, 32'h0880_0003);

        // Store then readback
        load_mar(32'h0000_01F4);
        load_mdr(32'hDEAD_BEEF);
        Mem_Write = 1; Mem_enable512x32 = 1; tick(); idle();
        check("store_cnt", {16'd0, wr_count}, 32'd1);
        rd(9'h1F4, d);
        check("store_readback", d, 32'hDEAD_BEEF);

        // Same-edge MAR/MDR load with write uses the old values
        load_mar(32'd3);
        load_mdr(32'h11);
        Mem_Write = 1; Mem_enable512x32 = 1; MARin = 1; MDRin = 1; BusMuxOut = 32'd7; tick(); idle();
        check("same_edge_mar", {23'd0, MAR_q}, 32'd7);
        check("same_edge_mdr", MDR_q, 32'd7);
        check("same_edge_cnt", {16'd0, wr_count}, 32'd2);
        rd(9'd3, d);
        check("same_edge_mem3", d, 32'h11);
        rd(9'd7, d);
        check("same_edge_mem7", d, 32'h77);
        load_mdr(32'h55);
        check("mdr_bus_load", MDR_q, 32'h55);

        // Read+write conflict
        load_mar(32'd2);
        Mem_Read = 1; Mem_Write = 1; Mem_enable512x32 = 1; MDRin = 1; tick(); idle();
        check("conflict_mdr", MDR_q, 32'hA);
        check("conflict_fault", {31'd0, mem_fault}, 32'd1);
        check("conflict_cnt", {16'd0, wr_count}, 32'd2);
        rd(9'd2, d);
        check("conflict_mem2", d, 32'hA);

        // Strobes without enable: no access, no fault
        reset = 1; tick(); idle();
        load_mar(32'd2);
        Mem_Read = 1; Mem_Write = 1; MDRin = 1; BusMuxOut = 32'h1234_5678; tick(); idle();
        check("noen_mdr", MDR_q, 32'h1234_5678);
        check("noen_fault", {31'd0, mem_fault}, 32'd0);

        // Preload while running is ignored and faults
        pre_we = 1; pre_addr = 9'd9; pre_data = 32'h0BAD; tick(); idle();
        check("pre_run_fault", {31'd0, mem_fault}, 32'd1);
        rd(9'd9, d);
        check("pre_run_mem9", d, 32'h99);

        // Reset coincident with a write
        load_mar(32'h10);
        load_mdr(32'h1234);
        reset = 1; Mem_Write = 1; Mem_enable512x32 = 1; tick(); idle();
        check("rstw_mar", {23'd0, MAR_q}, 32'd0);
        check("rstw_mdr", MDR_q, 32'd0);
        check("rstw_cnt", {16'd0, wr_count}, 32'd0);
        check("rstw_fault", {31'd0, mem_fault}, 32'd0);
        rd(9'h10, d);
        check("rstw_mem10", d, pre_vals[16]);
        rd(9'd5, d);
        check("rstw_mem5", d, 32'h0880_0003);

        // Preload and CPU write to the same word: CPU wins
        run = 0;
        load_mar(32'h40);
        load_mdr(32'hC0DE);
        Mem_Write = 1; Mem_enable512x32 = 1; pre_we = 1; pre_addr = 9'h40; pre_data = 32'hFFFF_0000;
        tick(); idle(); run = 1;
        rd(9'h40, d);
        check("pre_vs_cpu", d, 32'hC0DE);

        // Counter wrap
        reset = 1; tick(); idle();
        load_mar(32'h20);
        load_mdr(32'hCAFE);
        Mem_Write = 1; Mem_enable512x32 = 1;
        for (int i = 0; i < 65535; i++) tick();
        check("cnt_ffff", {16'd0, wr_count}, 32'h0000_FFFF);
        tick(); idle();
        check("cnt_wrap", {16'd0, wr_count}, 32'd0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 63) == 0);
            BusMuxOut        = $urandom;
            MARin            = $urandom_range(0, 2) == 0;
            MDRin            = $urandom_range(0, 1) == 0;
            Mem_Read         = $urandom_range(0, 2) == 0;
            Mem_Write        = $urandom_range(0, 2) == 0;
            Mem_enable512x32 = $urandom_range(0, 5) != 0;
            run              = $urandom_range(0, 3) != 0;
            pre_we           = $urandom_range(0, 3) == 0;
            pre_addr         = 9'($urandom);
            pre_data         = $urandom;
            tick();
        end
        idle();
        tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
